mcu_irq_controller: RTL and testbench
=====================================

MCU_IRQ_CONTROLLER -- requirements
Module: mcu_irq_controller

Interface
REQ-001 Parameter REG_IRQ_STATUS, default 16'h0010, opcode for the 4-byte pending-status read.
REQ-002 Parameter REG_IRQ_MASK, default 16'h0011, opcode for the 4-byte enable-mask write.
REQ-003 Parameter REG_IRQ_CLEAR, default 16'h0012, opcode for the 4-byte write-1-to-clear.
REQ-004 Clock and reset SHALL be one clock; reset is synchronous and active-high.
REQ-005 Port list, in this order:
- clk  in  1  system clock (QSPI bus clock domain).
- rst  in  1  synchronous active-high reset.
- event_pulse  in  32  per-source event strobes; a high bit in any cycle marks that source.
- start  in  1  CS# falling edge strobe.
- insn_valid  in  1  strobe, insn valid.
- insn  in  16  decoded instruction.
- wr_valid  in  1  strobe, wr_data valid.
- wr_data  in  8  write byte.
- rd_ready  in  1  strobe, host requests next read byte.
- rd_valid  out  1  strobe, rd_data valid.
- rd_data  out  8  read byte.
- rd_active  out  1  high while this block owns the read path.
- irq  out  1  interrupt to MCU.

Function
REQ-006 The block SHALL keep pending[31:0] (sticky) and mask[31:0] registers.
REQ-007 Each cycle, pending SHALL become (pending & ~clr_vec) | event_pulse, with clr_vec nonzero only in the cycle a clear commits.
- A set and a clear of the same bit in one cycle SHALL leave the bit set.
REQ-008 irq SHALL be registered: irq = |(pending & mask) as computed from the previous cycle's registers, giving one cycle of latency.
REQ-009 The FSM SHALL have the states IDLE, READ, WR_MASK, WR_CLEAR and DONE.
REQ-010 In any state, insn_valid SHALL reset byte_cnt to 0 and select the next state from insn:
- STATUS: go to READ, capture snapshot <= pending | event_pulse, and set rd_active = 1.
- MASK: go to WR_MASK.
- CLEAR: go to WR_CLEAR.
- Any other opcode: go to IDLE with rd_active = 0.
REQ-011 In READ, each rd_ready SHALL produce rd_valid = 1 on the next cycle.
- For byte_cnt 0 to 3, rd_data = snapshot[(3-byte_cnt)*8 +: 8], MSB first.
- For byte_cnt 4 and above, rd_data = 8'h00.
- byte_cnt SHALL saturate at 4.
REQ-012 A read SHALL NOT modify pending.
REQ-013 In WR_MASK or WR_CLEAR, each wr_valid SHALL shift wr_data into a 32-bit assembly register, MSB first, and increment byte_cnt.
REQ-014 When the 4th byte is received, the assembled word SHALL commit in that same clock edge:
- WR_MASK: mask <= word.
- WR_CLEAR: clr_vec = word, applied per REQ-007.
- The FSM SHALL then go to DONE.
REQ-015 Fewer than 4 bytes followed by start or a new insn_valid SHALL commit nothing.
REQ-016 In DONE or IDLE, wr_valid SHALL be ignored, and rd_ready SHALL return rd_data = 8'h00 with rd_valid.
REQ-017 start SHALL force the FSM to IDLE, byte_cnt = 0 and rd_active = 0.
- start SHALL NOT affect pending or mask.
- If start and insn_valid occur in the same cycle, insn_valid SHALL take priority.
REQ-018 rd_valid and the internal clear strobe SHALL be single-cycle pulses that default to 0.

Reset
REQ-019 While rst is high, the block SHALL hold pending = 0, mask = 0, snapshot = 0, byte_cnt = 0 and state = IDLE.
REQ-020 While rst is high, all outputs SHALL be 0: irq, rd_valid, rd_data and rd_active.
REQ-021 While rst is high, the block SHALL ignore event_pulse.
REQ-022 rst asserted mid-transaction SHALL abort the transaction with no partial commit.

Verification
REQ-023 Mask write then event:
- Stimulus: write MASK bytes 00 00 00 04, then pulse event_pulse[2].
- Required response: irq = 1 exactly 1 cycle after the pulse; pending = 32'h4.
REQ-024 Masked source:
- Stimulus: mask = 0, pulse event_pulse[5].
- Required response: irq stays 0; a STATUS read returns 00 00 00 20, and a 5th byte returns 00.
REQ-025 Clear racing an event:
- Stimulus: pending = 32'h24, mask = 32'hFFFFFFFF; write CLEAR 00 00 00 24 with event_pulse[2] high on the commit cycle.
- Required response: pending = 32'h4 and irq stays 1; with no event, pending = 0 and irq falls 1 cycle after the commit.
REQ-026 Aborted clear:
- Stimulus: write CLEAR 00 00, then start.
- Required response: pending unchanged.
REQ-027 Snapshot stability:
- Stimulus: pulse event_pulse[31] during a STATUS read.
- Required response: the read shows the old snapshot; the next STATUS read returns 80 ...
REQ-028 Reset during a read:
- Stimulus: rst asserted mid-read.
- Required response: all outputs 0, rd_active = 0, and mask = 0 afterward.

Source files
------------

// File: rtl/mcu_irq_controller.sv
// Interrupt controller reachable over a QSPI-style command interface.
// Holds a sticky 32-bit pending register fed by per-source event strobes and
// a 32-bit enable mask. The registered irq output is the OR of the enabled
// pending bits. The host reads pending through a snapshot taken when a STATUS
// command arrives. It writes the mask, or clears pending bits (write-1-to-clear),
// with 4-byte MSB-first transfers.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   event_pulse[31:0] per-source event strobes (sticky into pending)
//   start             CS# falling edge strobe, aborts any transfer
//   insn_valid, insn  decoded instruction strobe and opcode
//   wr_valid, wr_data host write byte
//   rd_ready          host requests the next read byte
//   rd_valid, rd_data read byte, valid one cycle after rd_ready
//   rd_active         high while a STATUS read owns the read path
//   irq               interrupt to MCU
module mcu_irq_controller #(
    parameter logic [15:0] REG_IRQ_STATUS = 16'h0010,
    parameter logic [15:0] REG_IRQ_MASK   = 16'h0011,
    parameter logic [15:0] REG_IRQ_CLEAR  = 16'h0012
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] event_pulse,
    input  logic        start,
    input  logic        insn_valid,
    input  logic [15:0] insn,
    input  logic        wr_valid,
    input  logic [7:0]  wr_data,
    input  logic        rd_ready,
    output logic        rd_valid,
    output logic [7:0]  rd_data,
    output logic        rd_active,
    output logic        irq
);

    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WR_MASK,
        S_WR_CLEAR,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [31:0]      pending_q, pending_d;
    logic [31:0]      mask_q, mask_d;
    logic [31:0]      snapshot_q, snapshot_d;
    logic [31:0]      asm_q, asm_d;
    logic             irq_q, irq_d;
    logic             rd_valid_q, rd_valid_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_active_q, rd_active_d;

    logic [31:0]      clr_vec;
    logic [31:0]      word;
    logic             wr_state;

    // State and register update; reset aborts any transfer without commit
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            byte_cnt_q  <= '0;
            pending_q   <= '0;
            mask_q      <= '0;
            snapshot_q  <= '0;
            asm_q       <= '0;
            irq_q       <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= 8'h00;
            rd_active_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            pending_q   <= pending_d;
            mask_q      <= mask_d;
            snapshot_q  <= snapshot_d;
            asm_q       <= asm_d;
            irq_q       <= irq_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            rd_active_q <= rd_active_d;
        end
    end

    // Next-state, transfer handling and pending/irq update
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        mask_d     = mask_q;
        snapshot_d = snapshot_q;
        asm_d      = asm_q;
        clr_vec    = '0;
        rd_valid_d = 1'b0;
        rd_data_d  = 8'h00;
        word       = {asm_q[23:0], wr_data};
        wr_state   = (state_q == S_WR_MASK) || (state_q == S_WR_CLEAR);

        // Every rd_ready gets a byte; only READ returns snapshot data
        if (rd_ready) begin
            rd_valid_d = 1'b1;
            if (state_q == S_READ) begin
                case (byte_cnt_q)
                    CNT_W'(0): rd_data_d = snapshot_q[31:24];
                    CNT_W'(1): rd_data_d = snapshot_q[23:16];
                    CNT_W'(2): rd_data_d = snapshot_q[15:8];
                    CNT_W'(3): rd_data_d = snapshot_q[7:0];
                    default:   rd_data_d = 8'h00;
                endcase
            end
        end

        if (insn_valid) begin
            // New instruction wins over start and drops any partial word
            byte_cnt_d = '0;
            if (insn == REG_IRQ_STATUS) begin
                state_d    = S_READ;
                snapshot_d = pending_q | event_pulse;
            end else if (insn == REG_IRQ_MASK) begin
                state_d = S_WR_MASK;
            end else if (insn == REG_IRQ_CLEAR) begin
                state_d = S_WR_CLEAR;
            end else begin
                state_d = S_IDLE;
            end
        end else if (start) begin
            state_d    = S_IDLE;
            byte_cnt_d = '0;
        end else begin
            if (rd_ready && (state_q == S_READ) && (byte_cnt_q != CNT_MAX)) begin
                byte_cnt_d = byte_cnt_q + CNT_W'(1);
            end
            if (wr_valid && wr_state) begin
                asm_d      = word;
                byte_cnt_d = byte_cnt_q + CNT_W'(1);
                // Fourth byte commits on this same edge
                if (byte_cnt_q == CNT_W'(3)) begin
                    if (state_q == S_WR_MASK) begin
                        mask_d = word;
                    end else begin
                        clr_vec = word;
                    end
                    state_d = S_DONE;
                end
            end
        end

        // A same-cycle event beats a clear of that bit
        pending_d   = (pending_q & ~clr_vec) | event_pulse;
        irq_d       = |(pending_q & mask_q);
        rd_active_d = (state_d == S_READ);
    end

    assign irq       = irq_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign rd_active = rd_active_q;

endmodule

// File: tb/tb_mcu_irq_controller.sv
// Directed bench for mcu_irq_controller. Read responses are queued as they are
// requested and checked by a separate monitor whenever rd_valid is seen.
module tb_mcu_irq_controller;

    localparam logic [15:0] OP_STATUS = 16'h0010;
    localparam logic [15:0] OP_MASK   = 16'h0011;
    localparam logic [15:0] OP_CLEAR  = 16'h0012;

    logic        clk;
    logic        rst;
    logic [31:0] event_pulse;
    logic        start;
    logic        insn_valid;
    logic [15:0] insn;
    logic        wr_valid;
    logic [7:0]  wr_data;
    logic        rd_ready;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        rd_active;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    mcu_irq_controller dut (
        .clk         (clk),
        .rst         (rst),
        .event_pulse (event_pulse),
        .start       (start),
        .insn_valid  (insn_valid),
        .insn        (insn),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .rd_ready    (rd_ready),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_active   (rd_active),
        .irq         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every rd_valid must match the oldest queued expectation
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got rd_data %h with no byte requested at %0t", rd_data, $time);
            end else begin
                chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic send_insn(input logic [15:0] op);
        insn_valid = 1'b1;
        insn       = op;
        @(negedge clk);
        insn_valid = 1'b0;
        insn       = 16'h0000;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic [31:0] ev);
        wr_valid    = 1'b1;
        wr_data     = b;
        event_pulse = ev;
        @(negedge clk);
        wr_valid    = 1'b0;
        event_pulse = '0;
    endtask

    task automatic read_byte(input logic [7:0] exp);
        exp_q.push_back(exp);
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
    endtask

    task automatic pulse(input logic [31:0] ev);
        event_pulse = ev;
        @(negedge clk);
        event_pulse = '0;
    endtask

    task automatic write_word(input logic [15:0] op, input logic [31:0] w);
        send_insn(op);
        for (int i = 0; i < 4; i++) send_byte(w[8*(3-i) +: 8], '0);
    endtask

    task automatic read_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) read_byte(w[8*(3-i) +: 8]);
    endtask

    task automatic status(input logic [31:0] w);
        send_insn(OP_STATUS);
        read_word(w);
    endtask

    initial begin
        rst = 1'b1; event_pulse = 32'hFFFF_FFFF; start = 1'b0;
        insn_valid = 1'b0; insn = '0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_rd_active", 32'(rd_active), 0);
        event_pulse = '0;
        rst = 1'b0;
        @(negedge clk);

        // Events during reset must not have been latched
        send_insn(OP_STATUS);
        chk("status_rd_active", 32'(rd_active), 1);
        read_word(32'h0000_0000);

        // Mask write then event on source 2
        write_word(OP_MASK, 32'h0000_0004);
        chk("irq_before_event", 32'(irq), 0);
        pulse(32'h0000_0004);
        @(negedge clk);
        chk("irq_after_event", 32'(irq), 1);
        status(32'h0000_0004);

        // Clear racing an event on the commit cycle
        pulse(32'h0000_0020);
        write_word(OP_MASK, 32'hFFFF_FFFF);
        chk("irq_all_enabled", 32'(irq), 1);
        send_insn(OP_CLEAR);
        send_byte(8'h00, '0);
        send_byte(8'h00, '0);
        send_byte(8'h00, '0);
        send_byte(8'h24, 32'h0000_0004);
        chk("irq_race_commit", 32'(irq), 1);
        @(negedge clk);
        chk("irq_race_after", 32'(irq), 1);
        status(32'h0000_0004);

        // Clear without event: irq falls one cycle after commit
        write_word(OP_CLEAR, 32'h0000_0004);
        chk("irq_clear_commit", 32'(irq), 1);
        @(negedge clk);
        chk("irq_clear_fall", 32'(irq), 0);

        // Masked source: irq stays low, read shows pending, extra bytes are zero
        write_word(OP_MASK, 32'h0000_0000);
        pulse(32'h0000_0020);
        chk("irq_masked_a", 32'(irq), 0);
        @(negedge clk);
        chk("irq_masked_b", 32'(irq), 0);
        status(32'h0000_0020);
        read_byte(8'h00);
        read_byte(8'h00);

        // Aborted clear by start, trailing bytes ignored in IDLE
        send_insn(OP_CLEAR);
        send_byte(8'h00, '0);
        send_byte(8'h00, '0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_rd_active", 32'(rd_active), 0);
        send_byte(8'h00, '0);
        send_byte(8'h20, '0);
        status(32'h0000_0020);

        // Aborted clear by a new instruction after three bytes
        send_insn(OP_CLEAR);
        send_byte(8'h00, '0);
        send_byte(8'h00, '0);
        send_byte(8'h00, '0);
        status(32'h0000_0020);

        // Snapshot stability during a read
        send_insn(OP_STATUS);
        read_byte(8'h00);
        read_byte(8'h00);
        pulse(32'h8000_0000);
        read_byte(8'h00);
        read_byte(8'h20);
        status(32'h8000_0020);

        // Unknown opcode releases the read path and returns zero
        send_insn(16'h0099);
        chk("unknown_rd_active", 32'(rd_active), 0);
        read_byte(8'h00);

        // insn_valid wins over start in the same cycle
        start = 1'b1;
        send_insn(OP_STATUS);
        start = 1'b0;
        chk("prio_rd_active", 32'(rd_active), 1);
        read_word(32'h8000_0020);

        // Reset during a read
        write_word(OP_MASK, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("irq_pre_reset", 32'(irq), 1);
        send_insn(OP_STATUS);
        read_byte(8'h80);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_rst_irq", 32'(irq), 0);
        chk("mid_rst_rd_valid", 32'(rd_valid), 0);
        chk("mid_rst_rd_data", 32'(rd_data), 0);
        chk("mid_rst_rd_active", 32'(rd_active), 0);
        rst = 1'b0;
        @(negedge clk);
        pulse(32'h0000_0001);
        @(negedge clk);
        chk("post_rst_mask_zero", 32'(irq), 0);
        status(32'h0000_0001);

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
